skew_feeder: RTL and testbench
==============================

SKEW_FEEDER -- requirements
Module: skew_feeder

Interface
REQ-001 Parameter: N, 31, MSB index of one data word; word width is N+1.
REQ-002 Parameter: SIZE, 4, systolic array dimension; buffer holds SIZE*SIZE words.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all registers update on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port load_valid, input, 1, load_data carries a valid matrix word.
REQ-006 The block SHALL have port load_data, input, N+1, matrix word, row-major order.
REQ-007 The block SHALL have port load_ready, output, 1, block accepts a word this cycle.
REQ-008 The block SHALL have port start, input, 1, begin streaming a fully loaded matrix.
REQ-009 The block SHALL have port full, output, 1, all SIZE*SIZE words are held.
REQ-010 The block SHALL have port out_data, output, SIZE*(N+1), lane i occupies bits [i*(N+1)+N : i*(N+1)] and drives array row i.
REQ-011 The block SHALL have port out_valid, output, 1, the current cycle is within a feed window.
REQ-012 The block SHALL have port done, output, 1, one-cycle pulse after the final feed cycle.

Function
REQ-013 The FSM SHALL have states LOAD, FULL and FEED; the reset state is LOAD.
REQ-014 In LOAD: load_ready=1; each cycle with load_valid=1 writes load_data to buffer[idx], where idx = row*SIZE + col, and increments idx.
REQ-015 When the word at idx=SIZE*SIZE-1 is accepted, the FSM SHALL go to FULL on the next edge; idx wraps to 0.
REQ-016 In FULL: full=1, load_ready=0, load_valid ignored; start=1 moves the FSM to FEED on the next edge.
REQ-017 start SHALL be ignored in LOAD (a partial matrix never streams) and in FEED.
REQ-018 FEED SHALL last exactly 2*SIZE-1 cycles, tracked by counter t = 0 .. 2*SIZE-2; out_valid=1 throughout.
REQ-019 At feed cycle t, lane i SHALL be driven from buffer[i*SIZE + (t-i)] when 0 <= t-i <= SIZE-1, and all-zero otherwise (skewed wavefront with zero padding).
REQ-020 Outputs SHALL be registered; the first lane-0 word appears on the first posedge after the start-accepting edge. Latency from start to first out_valid is one cycle.
REQ-021 Outputs SHALL be stable from posedge through the following negedge, where downstream PEs sample.
REQ-022 After cycle t=2*SIZE-2, the FSM SHALL go to LOAD. On that edge done pulses 1 for one cycle, out_valid drops to 0 and out_data returns to 0.
REQ-023 Outside FEED, out_data SHALL be all-zero and out_valid 0, so PEs accumulate nothing.
REQ-024 Buffer contents SHALL be preserved until overwritten by a new LOAD; there is no re-stream without reload.
REQ-025 Data SHALL pass through unmodified, with no arithmetic and no width change.
REQ-026 The counter widths SHALL cover SIZE*SIZE-1 and 2*SIZE-2 with no overflow for SIZE up to 16.

Reset
REQ-027 When rst_n=0, the following SHALL clear immediately regardless of clk: state=LOAD, idx=0, t=0, out_data=0, out_valid=0, done=0, full=0, load_ready=1 (reachable once released).
REQ-028 Buffer contents are not reset and are don't-care until reloaded.
REQ-029 Reset asserted mid-LOAD or mid-FEED SHALL abort the operation. The next operation SHALL be a full reload starting at idx=0.
REQ-030 Reset release SHALL be synchronised by the integrator; no posedge shall coincide with deassertion.

Verification
REQ-031 SIZE=4; load 1..16 with no gaps, then start -> full=1 after the 16th word. out_valid for 7 cycles. Lane0 = 1,2,3,4,0,0,0; lane1 = 0,5,6,7,8,0,0; lane3 = 0,0,0,13,14,15,16. done pulses 1 cycle later.
REQ-032 Load with load_valid toggling every other cycle -> only valid words are stored, and streamed values are identical to REQ-031.
REQ-033 start pulsed after 10 of 16 words -> no out_valid. Completing the load then start -> normal stream.
REQ-034 load_valid held high during FULL and FEED with value 0xDEAD -> the buffer is unchanged and the stream matches the loaded matrix.
REQ-035 rst_n dropped at feed cycle t=3 -> out_data=0 and out_valid=0 immediately with no clock edge. After release, load_ready=1, full=0 and no done pulse.
REQ-036 Load 0xFFFFFFFF in all 16 words -> every lane emits 0xFFFFFFFF for exactly 4 cycles with zeros elsewhere, confirming no truncation of the MSB.

Source files
------------

// File: rtl/skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : skew_feeder
//  Description : Buffers one SIZE x SIZE matrix loaded row-major, then streams
//                it into a systolic array as a skewed wavefront. Lane i is
//                delayed by i cycles, and zero padding fills the triangular gaps
//                on either side of the wavefront.
//  Revision    : 1.0 - initial release
// ============================================================================
module skew_feeder #(
    parameter int N    = 31,
    parameter int SIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    input  logic [N:0]            load_data,
    output logic                  load_ready,
    input  logic                  start,
    output logic                  full,
    output logic [SIZE*(N+1)-1:0] out_data,
    output logic                  out_valid,
    output logic                  done
);

    localparam int W     = N + 1;
    localparam int DEPTH = SIZE * SIZE;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int T_W   = (2 * SIZE - 1 > 1) ? $clog2(2 * SIZE - 1) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DEPTH - 1);
    localparam logic [T_W-1:0]   T_LAST   = T_W'(2 * SIZE - 2);
    localparam logic [T_W-1:0]   COL_MAX  = T_W'(SIZE - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        FULL = 2'd1,
        FEED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [T_W-1:0]      t_q, t_d;
    logic [SIZE*W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                done_q, done_d;

    // Matrix storage; deliberately not reset, contents are only meaningful
    // after a complete load.
    logic [W-1:0]        mem_q [DEPTH];

    logic                w_wr_en;
    logic [SIZE*W-1:0]   w_wave;

    // Next-state logic: load sequencing, start acceptance and feed counting.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        t_d     = t_q;
        done_d  = 1'b0;
        w_wr_en = 1'b0;
        case (state_q)
            LOAD: begin
                if (load_valid) begin
                    w_wr_en = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = FULL;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            FULL: begin
                if (start) begin
                    state_d = FEED;
                    t_d     = '0;
                end
            end
            FEED: begin
                if (t_q == T_LAST) begin
                    state_d = LOAD;
                    t_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    t_d = t_q + T_W'(1);
                end
            end
            default: begin
                state_d = LOAD;
                idx_d   = '0;
                t_d     = '0;
            end
        endcase
    end

    // Per-lane wavefront select. The word is looked up for the feed cycle that
    // becomes current after this edge (t_d), so the registered output lines up
    // with the counter value during that cycle.
    for (genvar gi = 0; gi < SIZE; gi++) begin : g_lane
        localparam logic [T_W-1:0]   LANE_T   = T_W'(gi);
        localparam logic [IDX_W-1:0] ROW_BASE = IDX_W'(gi * SIZE);

        logic [T_W-1:0] w_col;
        logic           w_in_win;
        logic [W-1:0]   w_word;

        // Select buffer[row*SIZE + (t-row)] inside the window, zero outside.
        always_comb begin
            w_col    = t_d - LANE_T;
            w_in_win = (t_d >= LANE_T) && (w_col <= COL_MAX);
            w_word   = '0;
            if (w_in_win) begin
                w_word = mem_q[ROW_BASE + IDX_W'(w_col)];
            end
        end

        assign w_wave[gi*W +: W] = w_word;
    end

    // Output next values: data and valid only while the next cycle is a feed cycle.
    always_comb begin
        out_valid_d = (state_d == FEED);
        out_data_d  = '0;
        if (out_valid_d) begin
            out_data_d = w_wave;
        end
    end

    // Control and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            idx_q       <= '0;
            t_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            t_q         <= t_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    // Buffer write port, active only for accepted words in LOAD.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[idx_q] <= load_data;
        end
    end

    assign load_ready = (state_q == LOAD);
    assign full       = (state_q == FULL);
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_skew_feeder
//  Description : Directed self-checking bench for skew_feeder (N=31, SIZE=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_skew_feeder;

    localparam int N    = 31;
    localparam int SIZE = 4;
    localparam int W    = N + 1;

    logic                  clk;
    logic                  rst_n;
    logic                  load_valid;
    logic [N:0]            load_data;
    logic                  load_ready;
    logic                  start;
    logic                  full;
    logic [SIZE*W-1:0]     out_data;
    logic                  out_valid;
    logic                  done;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_m [SIZE*SIZE];
    int           lane_hits [SIZE];

    skew_feeder #(.N(N), .SIZE(SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .start      (start),
        .full       (full),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Expected wavefront for feed cycle t, from the intended skew rule.
    function automatic logic [SIZE*W-1:0] wave(input int t);
        logic [SIZE*W-1:0] v;
        v = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (t - i >= 0 && t - i <= SIZE - 1) begin
                v[i*W +: W] = exp_m[i*SIZE + (t - i)];
            end
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_matrix(input bit gaps, input int first, input int count);
        for (int k = first; k < first + count; k++) begin
            load_valid = 1'b1;
            load_data  = exp_m[k];
            tick();
            if (gaps) begin
                load_valid = 1'b0;
                load_data  = 32'hBAD0BAD0;
                tick();
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic do_stream(input string tag);
        for (int i = 0; i < SIZE; i++) lane_hits[i] = 0;
        check({tag, "_pre_valid"}, {127'd0, out_valid}, 128'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 2*SIZE-1; t++) begin
            check($sformatf("%s_valid_t%0d", tag, t), {127'd0, out_valid}, 128'd1);
            check($sformatf("%s_data_t%0d", tag, t), out_data, wave(t));
            check($sformatf("%s_done_t%0d", tag, t), {127'd0, done}, 128'd0);
            for (int i = 0; i < SIZE; i++) begin
                if (out_data[i*W +: W] != '0) lane_hits[i]++;
            end
            tick();
        end
        check({tag, "_done_pulse"}, {127'd0, done}, 128'd1);
        check({tag, "_valid_drop"}, {127'd0, out_valid}, 128'd0);
        check({tag, "_data_zero"}, out_data, 128'd0);
        check({tag, "_ready_back"}, {127'd0, load_ready}, 128'd1);
        load_valid = 1'b0;
        tick();
        check({tag, "_done_clear"}, {127'd0, done}, 128'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        start      = 1'b0;
        #12;
        check("rst_ready", {127'd0, load_ready}, 128'd1);
        check("rst_full",  {127'd0, full},       128'd0);
        check("rst_valid", {127'd0, out_valid},  128'd0);
        check("rst_done",  {127'd0, done},       128'd0);
        check("rst_data",  out_data,             128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic load of 1..16 with no gaps.
        for (int k = 0; k < 16; k++) exp_m[k] = W'(k + 1);
        load_matrix(1'b0, 0, 15);
        check("basic_not_full_15", {127'd0, full}, 128'd0);
        load_matrix(1'b0, 15, 1);
        check("basic_full", {127'd0, full}, 128'd1);
        check("basic_ready_low", {127'd0, load_ready}, 128'd0);
        tick();
        check("basic_full_hold_valid", {127'd0, out_valid}, 128'd0);
        do_stream("basic");

        // Gapped load, same matrix.
        load_matrix(1'b1, 0, 16);
        check("gap_full", {127'd0, full}, 128'd1);
        do_stream("gap");

        // Start during a partial load is ignored.
        for (int k = 0; k < 16; k++) exp_m[k] = W'(32'h100 + k);
        load_matrix(1'b0, 0, 10);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("partial_no_valid", {127'd0, out_valid}, 128'd0);
        check("partial_not_full", {127'd0, full}, 128'd0);
        check("partial_ready", {127'd0, load_ready}, 128'd1);
        tick();
        check("partial_no_valid2", {127'd0, out_valid}, 128'd0);
        load_matrix(1'b0, 10, 6);
        check("partial_full", {127'd0, full}, 128'd1);
        do_stream("partial");

        // load_valid held with 0xDEAD during FULL and FEED.
        for (int k = 0; k < 16; k++) exp_m[k] = W'(32'hA000_0000 + 32'(k * 3));
        load_matrix(1'b0, 0, 16);
        load_valid = 1'b1;
        load_data  = 32'h0000DEAD;
        tick();
        tick();
        check("dead_still_full", {127'd0, full}, 128'd1);
        do_stream("dead");

        // Reset in the middle of a feed.
        for (int k = 0; k < 16; k++) exp_m[k] = W'(k + 1);
        load_matrix(1'b0, 0, 16);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("mid_t3_data", out_data, wave(3));
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {127'd0, out_valid}, 128'd0);
        check("mid_rst_data", out_data, 128'd0);
        check("mid_rst_ready", {127'd0, load_ready}, 128'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_post_ready", {127'd0, load_ready}, 128'd1);
        check("mid_post_full", {127'd0, full}, 128'd0);
        check("mid_post_done", {127'd0, done}, 128'd0);
        tick();
        check("mid_post_done2", {127'd0, done}, 128'd0);
        for (int k = 0; k < 16; k++) exp_m[k] = W'(32'h5000 + 32'(k * 7));
        load_matrix(1'b0, 0, 16);
        do_stream("reload");

        // All-ones matrix: MSB must survive, four nonzero cycles per lane.
        for (int k = 0; k < 16; k++) exp_m[k] = 32'hFFFFFFFF;
        load_matrix(1'b0, 0, 16);
        do_stream("ones");
        for (int i = 0; i < SIZE; i++) begin
            check($sformatf("ones_lane%0d_hits", i), 128'(lane_hits[i]), 128'd4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
